// File: rtl/ram_reader.sv
// -----------------------------------------------------------------------------
// ram_reader
//
// Read-side controller for the two-bank image RAM that feeds the stride-2
// convolution MAC. Each bank holds one IMG_W x IMG_W image. Once the writer
// flags the current bank as full, this block walks every K x K window at
// STRIDE spacing, issuing one RAM read per tap. It tags each returned datum
// with its kernel index and window/image boundaries, then hands the bank back
// to the writer. Banks are taken strictly in turn, starting with bank 0.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   bank_full     in   [1:0] level, bit b set = bank b holds a full image
//   out_ready     in   downstream accepts a new read issue this cycle
//   rAddr         out  [ADDR_W-1:0] RAM read address, valid with rd_en
//   rd_en         out  read issue strobe
//   data_valid    out  RAM read data valid (rd_en delayed one cycle)
//   tap           out  [3:0] kernel index ky*K+kx, aligned with data_valid
//   win_first     out  first tap of a window, aligned with data_valid
//   win_last      out  last tap of a window, aligned with data_valid
//   img_last      out  final datum of the bank, aligned with data_valid
//   bank_release  out  [1:0] one-cycle pulse on bit b when bank b is freed
// -----------------------------------------------------------------------------
module ram_reader #(
    parameter int IMG_W      = 9,
    parameter int K          = 3,
    parameter int STRIDE     = 2,
    parameter int BANK_WORDS = 81,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        bank_full,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] rAddr,
    output logic              rd_en,
    output logic              data_valid,
    output logic [3:0]        tap,
    output logic              win_first,
    output logic              win_last,
    output logic              img_last,
    output logic [1:0]        bank_release
);

    // Windows per row and per column.
    localparam int OUT_W = (IMG_W - K) / STRIDE + 1;

    // Counter widths; kept at least one bit so degenerate sizes still elaborate.
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int OW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        RELEASE
    } stateType;

    stateType state;
    stateType nextState;

    logic          curBank;
    logic [KW-1:0] kx;
    logic [KW-1:0] ky;
    logic [OW-1:0] ox;
    logic [OW-1:0] oy;

    logic kxLast;
    logic kyLast;
    logic oxLast;
    logic oyLast;
    logic lastIssue;

    logic [3:0] tapNow;

    logic [ADDR_W-1:0] bankBase;
    logic [ADDR_W-1:0] rowIdx;
    logic [ADDR_W-1:0] colIdx;

    // -------------------------------------------------------------------------
    // Counter wrap detection
    // -------------------------------------------------------------------------
    assign kxLast    = (kx == KW'(K - 1));
    assign kyLast    = (ky == KW'(K - 1));
    assign oxLast    = (ox == OW'(OUT_W - 1));
    assign oyLast    = (oy == OW'(OUT_W - 1));

    // The issue that carries the bottom-right tap of the bottom-right window.
    assign lastIssue = rd_en && kxLast && kyLast && oxLast && oyLast;

    assign tapNow    = 4'(ky) * 4'(K) + 4'(kx);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            curBank <= 1'b0;
        end else begin
            state <= nextState;
            // The bank flips as it is handed back, so the next IDLE already
            // looks at the other bank and the current one is never re-read.
            if (state == RELEASE) begin
                curBank <= ~curBank;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default first so no path through
    // the block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                // Only the bank whose turn it is matters; the other bank's
                // full flag is deliberately ignored to keep strict alternation.
                if (bank_full[curBank]) begin
                    nextState = READ;
                end
            end
            READ: begin
                // bank_full is not consulted here: the bank stays ours until
                // it is released, even if the writer drops the flag.
                if (lastIssue) begin
                    nextState = DRAIN;
                end
            end
            DRAIN: begin
                // Lets the final read return before the bank is handed back.
                nextState = RELEASE;
            end
            RELEASE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        rd_en        = 1'b0;
        bank_release = 2'b00;
        if (state == READ) begin
            // Back-pressure acts in the same cycle: no issue without permission.
            rd_en = out_ready;
        end
        if (state == RELEASE) begin
            bank_release[curBank] = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Window walk counters: kx fastest, then ky, then ox, then oy.
    // They only move on an actual issue, so a stall freezes the address and
    // nothing is skipped or repeated. After the last issue every counter has
    // wrapped back to zero, ready for the next image.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kx <= '0;
            ky <= '0;
            ox <= '0;
            oy <= '0;
        end else if (rd_en) begin
            if (!kxLast) begin
                kx <= kx + KW'(1);
            end else begin
                kx <= '0;
                if (!kyLast) begin
                    ky <= ky + KW'(1);
                end else begin
                    ky <= '0;
                    if (!oxLast) begin
                        ox <= ox + OW'(1);
                    end else begin
                        ox <= '0;
                        if (!oyLast) begin
                            oy <= oy + OW'(1);
                        end else begin
                            oy <= '0;
                        end
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Address generation from the registered counters.
    // Row within the image is oy*STRIDE+ky, column is ox*STRIDE+kx; both stay
    // below IMG_W, so the address never leaves the active bank.
    // -------------------------------------------------------------------------
    always_comb begin
        bankBase = curBank ? ADDR_W'(BANK_WORDS) : '0;
        rowIdx   = ADDR_W'(oy) * ADDR_W'(STRIDE) + ADDR_W'(ky);
        colIdx   = ADDR_W'(ox) * ADDR_W'(STRIDE) + ADDR_W'(kx);
        rAddr    = bankBase + rowIdx * ADDR_W'(IMG_W) + colIdx;
    end

    // -------------------------------------------------------------------------
    // Tag pipeline: matches the one-cycle RAM read latency so the tags arrive
    // with the data. Tags are forced to zero on cycles without an issue so
    // they never assert outside data_valid.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_valid <= 1'b0;
            tap        <= '0;
            win_first  <= 1'b0;
            win_last   <= 1'b0;
            img_last   <= 1'b0;
        end else begin
            data_valid <= rd_en;
            tap        <= rd_en ? tapNow : '0;
            win_first  <= rd_en && (tapNow == 4'd0);
            win_last   <= rd_en && kxLast && kyLast;
            img_last   <= lastIssue;
        end
    end

endmodule

// File: doc/ram_reader.md
Name: ram_reader

Overview:
- Read-side controller for the two-bank image RAM used by the 2D stride-2 convolution datapath.
- Bank 0 occupies words 0..80 and bank 1 occupies words 81..161; each bank holds one 9x9 image.
- Waits until the writer marks a bank full, then issues a 3x3 window read sequence at stride 2 over it (16 windows x 9 taps = 144 reads), tags each datum for the MAC, and releases the bank back to the writer.
- Banks are consumed in strict alternation, starting with bank 0.

Parameters:
- IMG_W, 9: image width and height in words.
- K, 3: kernel width and height.
- STRIDE, 2: window step in x and y.
- BANK_WORDS, 81: words per bank; bank b base address = b*BANK_WORDS.
- ADDR_W, 10: RAM address width.
- OUT_W, (IMG_W-K)/STRIDE+1 = 4: windows per row and per column (derived).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- bank_full  in  2  level; bit b=1 means bank b holds a complete image (driven by the writer).
- out_ready  in  1  downstream permits a new read issue this cycle.
- rAddr  out  ADDR_W  RAM read address, valid when rd_en=1.
- rd_en  out  1  read issue strobe.
- data_valid  out  1  RAM read data valid this cycle (rd_en delayed one cycle).
- tap  out  4  kernel index ky*K+kx (0..8), aligned with data_valid.
- win_first  out  1  aligned with data_valid; tap==0.
- win_last  out  1  aligned with data_valid; tap==8.
- img_last  out  1  aligned with data_valid; final datum of the bank.
- bank_release  out  2  one-cycle pulse on bit b when bank b is freed.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, cur_bank=0, counters kx/ky/ox/oy=0.
  - rd_en=0, data_valid=0, tap=0, win_first=0, win_last=0, img_last=0, bank_release=0, rAddr=0.
  - Reset mid-sequence abandons the image; no release pulse is generated. The writer is reset together with this block.
- States: IDLE, READ, DRAIN, RELEASE.
  - IDLE: if bank_full[cur_bank]=1, go to READ next cycle. Otherwise hold; bank_full[~cur_bank] is ignored.
  - READ: rd_en = out_ready (combinational). Counters advance only on cycles where rd_en=1.
  - Counter order: kx fastest, then ky, then ox, then oy (each kx/ky wraps at K-1, each ox/oy wraps at OUT_W-1).
  - Leave READ after the rd_en cycle with kx=ky=2, ox=oy=3 and go to DRAIN.
  - DRAIN: one cycle; rd_en=0. The final datum emerges with img_last=1.
  - RELEASE: one cycle; bank_release[cur_bank]=1, cur_bank toggles, go to IDLE.
- Address: rAddr = cur_bank*BANK_WORDS + (oy*STRIDE+ky)*IMG_W + ox*STRIDE + kx.
  - Computed from registered counters; the result must fit within ADDR_W.
  - Maximum address is 161. No address outside the active bank is ever issued.
- Pipeline (one-cycle RAM read latency):
  - data_valid, tap, win_first, win_last and img_last are registered copies of rd_en and the counter-derived tags.
  - With out_ready held high, exactly 144 consecutive rd_en cycles occur.
  - Timing from IDLE: bank_full seen in cycle T, first rd_en in T+1, last rd_en in T+144, DRAIN in T+145, release pulse in T+146, IDLE in T+147.
- Stall: out_ready=0 in READ drops rd_en and freezes the counters and rAddr.
  - A datum issued in the previous cycle still appears, so downstream must accept one in-flight word after deasserting out_ready.
  - No address is skipped or duplicated across a stall.
- bank_full deasserting during READ is ignored; the bank is owned by the reader until release.
- Both banks full: the reader finishes cur_bank, releases it, then takes the other bank from IDLE. There is a 2-cycle gap (RELEASE, IDLE) between images.

Test Plan:
- Reset check: hold reset=0 with random inputs -> every output is 0 and no rd_en occurs.
- Bank 0, out_ready=1:
  - First window is 0,1,2,9,10,11,18,19,20; second window is 2,3,4,11,12,13,20,21,22.
  - Window 5 starts at 18; the last window is 60,61,62,69,70,71,78,79,80.
  - 144 reads total; win_last pulses 16 times; img_last is seen once, on address 80's datum.
  - bank_release[0] pulses 2 cycles after the final rd_en.
- Then bank_full=2'b10 -> the sequence repeats offset by 81 (first address 81, last 161), followed by a bank_release[1] pulse.
- out_ready toggled pseudo-randomly during bank 0 -> the issued address list is identical to the 144-entry golden list, and data_valid count = rd_en count.
- After bank 0 is released, hold bank_full=2'b01 (bank 1 empty) -> the block stays in IDLE with rd_en=0 indefinitely; no re-read of bank 0.
- Assert reset=0 midway (after 50 reads), then deassert -> outputs clear asynchronously, no bank_release pulse, and the next image starts at address 0 with bank 0.
